// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two request handshakes, the regfile write port and the
// pass-through read ports with their forwarded results.
interface regfile_wb_arbiter_if;
   logic        req0_valid_i;
   logic [4:0]  req0_addr_i;
   logic [31:0] req0_data_i;
   logic        req0_ready_o;
   logic        req1_valid_i;
   logic [4:0]  req1_addr_i;
   logic [31:0] req1_data_i;
   logic        req1_ready_o;
   logic [4:0]  rf_addr_3_o;
   logic [31:0] rf_write_data_3_o;
   logic        rf_write_enable_o;
   logic [4:0]  rd_addr_1_i;
   logic [4:0]  rd_addr_2_i;
   logic [31:0] rf_read_data_1_i;
   logic [31:0] rf_read_data_2_i;
   logic [31:0] read_data_1_o;
   logic [31:0] read_data_2_o;
   logic        busy_o;

   // Writeback stages / regfile side.
   modport master (
      output req0_valid_i, req0_addr_i, req0_data_i,
      output req1_valid_i, req1_addr_i, req1_data_i,
      output rd_addr_1_i, rd_addr_2_i, rf_read_data_1_i, rf_read_data_2_i,
      input  req0_ready_o, req1_ready_o,
      input  rf_addr_3_o, rf_write_data_3_o, rf_write_enable_o,
      input  read_data_1_o, read_data_2_o, busy_o
   );

   // Arbiter side.
   modport slave (
      input  req0_valid_i, req0_addr_i, req0_data_i,
      input  req1_valid_i, req1_addr_i, req1_data_i,
      input  rd_addr_1_i, rd_addr_2_i, rf_read_data_1_i, rf_read_data_2_i,
      output req0_ready_o, req1_ready_o,
      output rf_addr_3_o, rf_write_data_3_o, rf_write_enable_o,
      output read_data_1_o, read_data_2_o, busy_o
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port between the main pipeline writeback (req0)
// and a multi-cycle source (req1). Each source owns a one-entry buffer; buffered
// writes are forwarded onto both read ports so readers never see stale data.
module regfile_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                 clk,
   input logic                 reset_i,
   regfile_wb_arbiter_if.slave bus
);

   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

   logic        buf0_full_q, buf0_full_d;
   logic [4:0]  buf0_addr_q, buf0_addr_d;
   logic [31:0] buf0_data_q, buf0_data_d;
   logic        buf1_full_q, buf1_full_d;
   logic [4:0]  buf1_addr_q, buf1_addr_d;
   logic [31:0] buf1_data_q, buf1_data_d;
   // 1: buf1 holds the newer entry, 0: buf0 does.
   logic        newer_q, newer_d;
   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

   logic grant0, grant1;
   logic accept0, accept1;

   // Pick at most one full buffer to drain this cycle.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (buf0_full_q && buf1_full_q) begin
         if ((buf0_addr_q == buf1_addr_q) && (buf0_addr_q != 5'd0)) begin
            // Same destination: the older write must land first.
            if (newer_q) grant0 = 1'b1;
            else         grant1 = 1'b1;
         end else if (starve_cnt_q >= CntW'(STARVE_LIMIT)) begin
            grant1 = 1'b1;
         end else begin
            grant0 = 1'b1;
         end
      end else if (buf0_full_q) begin
         grant0 = 1'b1;
      end else if (buf1_full_q) begin
         grant1 = 1'b1;
      end
   end

   // Regfile write port; writes to r0 are drained without enabling the write.
   always_comb begin
      bus.rf_addr_3_o       = 5'd0;
      bus.rf_write_data_3_o = 32'd0;
      bus.rf_write_enable_o = 1'b0;
      if (grant0) begin
         bus.rf_addr_3_o       = buf0_addr_q;
         bus.rf_write_data_3_o = buf0_data_q;
         bus.rf_write_enable_o = (buf0_addr_q != 5'd0);
      end else if (grant1) begin
         bus.rf_addr_3_o       = buf1_addr_q;
         bus.rf_write_data_3_o = buf1_data_q;
         bus.rf_write_enable_o = (buf1_addr_q != 5'd0);
      end
   end

   // Handshake outputs: a buffer draining this edge may refill on the same edge.
   always_comb begin
      bus.req0_ready_o = ~buf0_full_q | grant0;
      bus.req1_ready_o = ~buf1_full_q | grant1;
      bus.busy_o       = buf0_full_q | buf1_full_q;
      accept0          = bus.req0_valid_i & bus.req0_ready_o;
      accept1          = bus.req1_valid_i & bus.req1_ready_o;
   end

   function automatic logic [31:0] fwd(input logic [4:0]  rd_addr,
                                       input logic [31:0] raw,
                                       input logic        f0,
                                       input logic [4:0]  a0,
                                       input logic [31:0] d0,
                                       input logic        f1,
                                       input logic [4:0]  a1,
                                       input logic [31:0] d1,
                                       input logic        newer1);
      logic m0, m1;
      m0 = f0 && (a0 == rd_addr);
      m1 = f1 && (a1 == rd_addr);
      if (rd_addr == 5'd0)  return 32'd0;
      else if (m0 && m1)    return newer1 ? d1 : d0;
      else if (m0)          return d0;
      else if (m1)          return d1;
      else                  return raw;
   endfunction

   // Read-port forwarding from the holding buffers (not from request inputs).
   always_comb begin
      bus.read_data_1_o = fwd(bus.rd_addr_1_i, bus.rf_read_data_1_i, buf0_full_q, buf0_addr_q,
                              buf0_data_q, buf1_full_q, buf1_addr_q, buf1_data_q, newer_q);
      bus.read_data_2_o = fwd(bus.rd_addr_2_i, bus.rf_read_data_2_i, buf0_full_q, buf0_addr_q,
                              buf0_data_q, buf1_full_q, buf1_addr_q, buf1_data_q, newer_q);
   end

   // Next-state for buffers, age flag and starvation counter.
   always_comb begin
      buf0_full_d  = buf0_full_q;
      buf0_addr_d  = buf0_addr_q;
      buf0_data_d  = buf0_data_q;
      buf1_full_d  = buf1_full_q;
      buf1_addr_d  = buf1_addr_q;
      buf1_data_d  = buf1_data_q;
      newer_d      = newer_q;
      starve_cnt_d = starve_cnt_q;

      if (grant0) buf0_full_d = 1'b0;
      if (grant1) buf1_full_d = 1'b0;
      if (accept0) begin
         buf0_full_d = 1'b1;
         buf0_addr_d = bus.req0_addr_i;
         buf0_data_d = bus.req0_data_i;
      end
      if (accept1) begin
         buf1_full_d = 1'b1;
         buf1_addr_d = bus.req1_addr_i;
         buf1_data_d = bus.req1_data_i;
      end

      // Simultaneous loads count req1 as the newer entry.
      if (accept1)      newer_d = 1'b1;
      else if (accept0) newer_d = 1'b0;

      if (!buf1_full_q || grant1) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < CntW'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   // State registers; reset discards any buffered writes.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         buf0_full_q  <= 1'b0;
         buf0_addr_q  <= 5'd0;
         buf0_data_q  <= 32'd0;
         buf1_full_q  <= 1'b0;
         buf1_addr_q  <= 5'd0;
         buf1_data_q  <= 32'd0;
         newer_q      <= 1'b0;
         starve_cnt_q <= '0;
      end else begin
         buf0_full_q  <= buf0_full_d;
         buf0_addr_q  <= buf0_addr_d;
         buf0_data_q  <= buf0_data_d;
         buf1_full_q  <= buf1_full_d;
         buf1_addr_q  <= buf1_addr_d;
         buf1_data_q  <= buf1_data_d;
         newer_q      <= newer_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with STARVE_LIMIT = 4.
module tb_regfile_wb_arbiter;

   logic clk;
   logic reset_i;
   int   total;
   int   bad;

   logic [31:0] rf_model [32];

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter #(
      .STARVE_LIMIT(4)
   ) dut (
      .clk    (clk),
      .reset_i(reset_i),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference regfile fed by the arbiter's write port.
   always @(posedge clk) begin
      if (bus.rf_write_enable_o) rf_model[bus.rf_addr_3_o] <= bus.rf_write_data_3_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set0(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.req0_valid_i = v;
      bus.req0_addr_i  = a;
      bus.req0_data_i  = d;
   endtask

   task automatic set1(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.req1_valid_i = v;
      bus.req1_addr_i  = a;
      bus.req1_data_i  = d;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset_i = 1'b0;
      set0(1'b0, 5'd0, 32'd0);
      set1(1'b0, 5'd0, 32'd0);
      bus.rd_addr_1_i      = 5'd3;
      bus.rd_addr_2_i      = 5'd0;
      bus.rf_read_data_1_i = 32'h1234_5678;
      bus.rf_read_data_2_i = 32'h8765_4321;
      #1;
      chk("rst_we", bus.rf_write_enable_o, 0);
      chk("rst_busy", bus.busy_o, 0);

      // 1) reset released, idle
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      chk("idle_we", bus.rf_write_enable_o, 0);
      chk("idle_rdy0", bus.req0_ready_o, 1);
      chk("idle_rdy1", bus.req1_ready_o, 1);
      chk("idle_busy", bus.busy_o, 0);
      chk("idle_addr3", bus.rf_addr_3_o, 0);
      chk("idle_data3", bus.rf_write_data_3_o, 0);
      chk("idle_rd1", bus.read_data_1_o, 32'h1234_5678);
      chk("idle_rd2_r0", bus.read_data_2_o, 0);

      // 2) single req0 write with forwarding
      set0(1'b1, 5'd5, 32'hDEAD_BEEF);
      bus.rd_addr_1_i      = 5'd5;
      bus.rf_read_data_1_i = 32'd0;
      @(negedge clk);
      chk("w0_we", bus.rf_write_enable_o, 1);
      chk("w0_addr", bus.rf_addr_3_o, 5);
      chk("w0_data", bus.rf_write_data_3_o, 32'hDEAD_BEEF);
      chk("w0_fwd", bus.read_data_1_o, 32'hDEAD_BEEF);
      chk("w0_busy", bus.busy_o, 1);
      chk("w0_rdy0", bus.req0_ready_o, 1);
      set0(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("w0_drained", bus.busy_o, 0);
      chk("w0_raw", bus.read_data_1_o, 0);
      chk("w0_model", rf_model[5], 32'hDEAD_BEEF);

      // 3) continuous contention: four req0 grants then one req1 grant, repeating
      set0(1'b1, 5'd1, 32'h100);
      set1(1'b1, 5'd2, 32'h200);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("starve_addr%0d", i), bus.rf_addr_3_o,
             ((i == 4) || (i == 9)) ? 32'd2 : 32'd1);
         if (i == 0) chk("starve_rdy1", bus.req1_ready_o, 0);
      end
      set0(1'b0, 5'd0, 32'd0);
      set1(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("starve_tail", bus.rf_addr_3_o, 1);
      @(negedge clk);
      chk("starve_empty", bus.busy_o, 0);

      // 4a) req0 r7=1 then req1 r7=2 on consecutive edges
      bus.rd_addr_1_i      = 5'd7;
      bus.rf_read_data_1_i = 32'hAAAA;
      set0(1'b1, 5'd7, 32'h1);
      @(negedge clk);
      chk("ord_a_d1", bus.rf_write_data_3_o, 1);
      chk("ord_a_f1", bus.read_data_1_o, 1);
      set0(1'b0, 5'd0, 32'd0);
      set1(1'b1, 5'd7, 32'h2);
      @(negedge clk);
      chk("ord_a_d2", bus.rf_write_data_3_o, 2);
      chk("ord_a_f2", bus.read_data_1_o, 2);
      set1(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("ord_a_raw", bus.read_data_1_o, 32'hAAAA);
      chk("ord_a_model", rf_model[7], 2);

      // 4b) both load r7 on the same edge: req1 is newer, req0 drains first
      set0(1'b1, 5'd7, 32'h11);
      set1(1'b1, 5'd7, 32'h22);
      @(negedge clk);
      chk("ord_b_d1", bus.rf_write_data_3_o, 32'h11);
      chk("ord_b_fwd", bus.read_data_1_o, 32'h22);
      chk("ord_b_rdy1", bus.req1_ready_o, 0);
      set0(1'b0, 5'd0, 32'd0);
      set1(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("ord_b_d2", bus.rf_write_data_3_o, 32'h22);
      @(negedge clk);
      chk("ord_b_model", rf_model[7], 32'h22);

      // 4c) older buf1 wins over req0 priority on an address clash
      bus.rd_addr_2_i = 5'd8;
      set0(1'b1, 5'd3, 32'h33);
      set1(1'b1, 5'd8, 32'h88);
      @(negedge clk);
      chk("ord_c_a1", bus.rf_addr_3_o, 3);
      set0(1'b1, 5'd8, 32'h99);
      set1(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("ord_c_d1", bus.rf_write_data_3_o, 32'h88);
      chk("ord_c_fwd", bus.read_data_2_o, 32'h99);
      set0(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("ord_c_d2", bus.rf_write_data_3_o, 32'h99);
      @(negedge clk);
      chk("ord_c_model", rf_model[8], 32'h99);

      // 5) write to r0 is drained without enabling the regfile
      bus.rd_addr_1_i      = 5'd0;
      bus.rf_read_data_1_i = 32'h5555;
      set1(1'b1, 5'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("r0_we", bus.rf_write_enable_o, 0);
      chk("r0_busy", bus.busy_o, 1);
      chk("r0_rd", bus.read_data_1_o, 0);
      set1(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("r0_drained", bus.busy_o, 0);

      // 6) asynchronous reset with both buffers full
      set0(1'b1, 5'd10, 32'hA);
      set1(1'b1, 5'd11, 32'hB);
      @(negedge clk);
      chk("ar_busy_pre", bus.busy_o, 1);
      #1 reset_i = 1'b0;
      #1;
      chk("ar_we", bus.rf_write_enable_o, 0);
      chk("ar_busy", bus.busy_o, 0);
      chk("ar_rdy0", bus.req0_ready_o, 1);
      chk("ar_rdy1", bus.req1_ready_o, 1);
      chk("ar_addr3", bus.rf_addr_3_o, 0);
      chk("ar_data3", bus.rf_write_data_3_o, 0);
      set0(1'b0, 5'd0, 32'd0);
      set1(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      chk("ar_after", bus.busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
